fifo_stream_reader: RTL and testbench

- Read-side companion to the team's synchronous FIFO in registered-output mode, i.e. FIRST_WORD_FALLTHROUGH=0, where dout updates one cycle after rd_en.
- Drains the FIFO and presents its words as a valid/ready stream to a downstream consumer (decode, LSU response path, peripherals).
- Holds words in a 2-entry output buffer, so it absorbs the FIFO's read latency and consumer backpressure without losing or duplicating a word.
- Also supports a synchronous flush and keeps a delivered-word counter.

---
 rtl/fifo_stream_reader.sv | 63 ++++++
 tb/tb_fifo_stream_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a registered-output synchronous FIFO. It turns the FIFO's
// one-cycle read latency into a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 fifo_empty,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  input  logic                 flush,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  logic [1:0]       occ;
  logic             pend;
  logic [WIDTH-1:0] slot0, slot1;
  logic             pop;
  logic [1:0]       surv;
  logic [2:0]       need;

  assign pop  = (occ != 2'd0) && m_ready;
  assign surv = occ - {1'b0, pop};
  // Words that will occupy the buffer after this edge; a new read is only
  // issued when its data is guaranteed a free slot one cycle later.
  assign need = {1'b0, surv} + {2'b00, pend};

  assign fifo_rd_en = rst_n && !flush && !fifo_empty && (need <= 3'd1);

  assign m_valid = (occ != 2'd0);
  assign m_data  = slot0;
  assign busy    = (occ != 2'd0) || pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ        <= 2'd0;
      pend       <= 1'b0;
      slot0      <= '0;
      slot1      <= '0;
      xfer_count <= '0;
    end else begin
      pend <= fifo_rd_en;
      if (pop) xfer_count <= xfer_count + CNT_WIDTH'(1);
      if (flush) begin
        occ <= 2'd0;
      end else begin
        occ <= need[1:0];
        if (pop && surv == 2'd1) slot0 <= slot1;
        // Arriving word lands directly behind whatever survives the pop.
        if (pend) begin
          if (surv == 2'd0) slot0 <= fifo_dout;
          else              slot1 <= fifo_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO and buffer model, directed
// scenarios with literal expectations, then a randomized run.
module tb_fifo_stream_reader;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_dout;
  logic          fifo_empty;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready;
  logic          flush;
  logic          busy;
  logic [CW-1:0] xfer_count;

  fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .flush(flush), .busy(busy), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // FIFO contents and the words the reader should currently be holding
  logic [W-1:0] fq[$];
  logic [W-1:0] mb[$];
  logic         infl = 1'b0;
  int           cnt = 0;
  logic         force_ne = 1'b0;
  logic         ord_on = 1'b0;
  logic         have_last = 1'b0;
  logic [W-1:0] last_w = '0;
  logic         st_prev = 1'b0;
  logic [W-1:0] st_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: compare on the falling edge, then advance the model after the rising edge.
  task automatic tick();
    logic         ev, eb, erd, pop, s_rd, s_rst, s_flush;
    logic [W-1:0] ed, s_dout;
    logic [W-1:0] d;
    @(negedge clk);
    ev  = (mb.size() != 0);
    ed  = ev ? mb[0] : '0;
    eb  = ev || infl;
    pop = ev && m_ready;
    erd = rst_n && !flush && !fifo_empty &&
          (int'(mb.size()) + int'(infl) - int'(pop) <= 1);
    chk("rd_en", fifo_rd_en, erd);
    if (rst_n) begin
      chk("m_valid", m_valid, ev);
      chk("busy", busy, eb);
      chk("xfer_count", xfer_count, cnt);
      if (ev) chk("m_data", m_data, ed);
      if (st_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, st_data);
      end
      if (ord_on && m_valid && m_ready) begin
        if (have_last) begin
          d = m_data - last_w;
          n_chk++;
          if (d < 1 || d > 4) begin
            n_fail++;
            $display("FAIL order: got %0h after %0h, required successor within 1..4", m_data, last_w);
          end
        end
        have_last = 1'b1;
        last_w = m_data;
      end
    end
    if (fifo_rd_en && fifo_empty) begin
      n_chk++; n_fail++;
      $display("FAIL rd_on_empty: got rd_en=1 with fifo_empty=1, required rd_en=0");
    end
    st_prev = rst_n && !flush && m_valid && !m_ready;
    st_data = m_data;
    s_rd = fifo_rd_en; s_dout = fifo_dout; s_rst = rst_n; s_flush = flush;
    @(posedge clk);
    #1;
    if (!s_rst) begin
      mb.delete(); fq.delete();
      infl = 1'b0; cnt = 0; have_last = 1'b0;
    end else begin
      if (pop) begin
        void'(mb.pop_front());
        cnt = (cnt + 1) % (1 << CW);
      end
      if (s_flush) mb.delete();
      else if (infl) mb.push_back(s_dout);
      infl = s_rd;
    end
    if (s_rst && s_rd && fq.size() > 0) fifo_dout = fq.pop_front();
    else fifo_dout = W'($urandom);
    fifo_empty = force_ne ? 1'b0 : (fq.size() == 0);
  endtask

  int pulses;
  logic [W-1:0] seq;

  initial begin
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b1;
    force_ne = 1'b1; fifo_empty = 1'b0; fifo_dout = 8'h5A;
    tick();
    // reset holds everything idle even with a non-empty FIFO
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_xfer", xfer_count, 0);
      tick();
    end
    force_ne = 1'b0; fifo_empty = 1'b1; rst_n = 1'b1;
    tick(); tick();

    // streaming at full rate
    push(8'h11); push(8'h22); push(8'h33);
    #1;
    chk("s_rd_t0", fifo_rd_en, 1); tick();
    chk("s_rd_t1", fifo_rd_en, 1); chk("s_valid_t1", m_valid, 0); tick();
    chk("s_rd_t2", fifo_rd_en, 1); chk("s_valid_t2", m_valid, 1); chk("s_data_t2", m_data, 8'h11); tick();
    chk("s_valid_t3", m_valid, 1); chk("s_data_t3", m_data, 8'h22); tick();
    chk("s_valid_t4", m_valid, 1); chk("s_data_t4", m_data, 8'h33); tick();
    chk("s_busy_t5", busy, 0); chk("s_xfer_t5", xfer_count, 3);

    // backpressure: only two reads outstanding
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hA0 + W'(i));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      #1; pulses += int'(fifo_rd_en); tick();
    end
    chk("bp_pulses", pulses, 2);
    chk("bp_data", m_data, 8'hA0);
    chk("bp_rd_low", fifo_rd_en, 0);
    m_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", m_valid, 1);
      chk("bp_drain_data", m_data, 8'hA0 + W'(i));
      tick();
    end
    chk("bp_xfer", xfer_count, 7);

    // flush with one buffered word and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hB0 + W'(i));
    #1; chk("f_rd0", fifo_rd_en, 1); tick();
    chk("f_rd1", fifo_rd_en, 1); tick();
    chk("f_pre_valid", m_valid, 1); chk("f_pre_data", m_data, 8'hB0); chk("f_pre_busy", busy, 1);
    flush = 1'b1;
    #1; chk("f_rd_flush", fifo_rd_en, 0); tick();
    flush = 1'b0;
    #1;
    chk("f_post_valid", m_valid, 0); chk("f_post_busy", busy, 0); chk("f_post_xfer", xfer_count, 7);
    m_ready = 1'b1;
    for (int k = 0; k < 6 && !m_valid; k++) tick();
    chk("f_next_valid", m_valid, 1); chk("f_next_data", m_data, 8'hB2); tick();
    chk("f_next2_data", m_data, 8'hB3); tick();
    chk("f_xfer", xfer_count, 9);

    // counter wrap: 17 transfers from reset on a 4-bit counter
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 17; i++) push(8'h40 + W'(i));
    for (int i = 0; i < 24; i++) tick();
    chk("wrap_xfer", xfer_count, 1);
    chk("wrap_busy", busy, 0);

    // randomized traffic
    ord_on = 1'b1; have_last = 1'b0; seq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 499) != 0);
      flush   = ($urandom_range(0, 31) == 0);
      m_ready = ($urandom_range(0, 9) < 7);
      if (fq.size() < 5 && $urandom_range(0, 1) == 1) begin
        push(seq);
        seq = seq + 8'd1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
